// File: rtl/irq_request_latch.sv
`default_nettype none
// ============================================================================
// Module   : irq_request_latch
// Brief    : Edge-latches four IRQ lines, feeds the priority encoder and hands
//            the winner to the core over valid/ack. IRQ_LATCH_SYNC_EN adds a
//            2-flop input synchroniser.
// Revision : 1.0 - initial release
// ============================================================================
module irq_request_latch #(
  parameter int CHANNELS = 4,
  parameter int CODE_W   = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] irq_in,
  input  logic [CHANNELS-1:0] mask,
  output logic [CHANNELS-1:0] pend_out,
  input  logic [CODE_W-1:0]   enc_code,
  output logic                irq_valid,
  output logic [CODE_W-2:0]   irq_id,
  input  logic                irq_ack,
  output logic [CHANNELS-1:0] overrun,
  input  logic                clr_overrun
);

  localparam logic [0:0] c_IDLE    = 1'b0;
  localparam logic [0:0] c_PRESENT = 1'b1;

  logic [CHANNELS-1:0] w_s;
  logic [CHANNELS-1:0] r_prev;
  logic [CHANNELS-1:0] w_edge;
  logic [CHANNELS-1:0] w_clr;
  logic [CHANNELS-1:0] r_pend;
  logic [CHANNELS-1:0] r_ovr;
  logic [0:0]          r_state;
  logic [CODE_W-2:0]   r_irq_id;
  logic                w_ack;

`ifdef IRQ_LATCH_SYNC_EN
  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= irq_in;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;
`else
  assign w_s = irq_in;
`endif

  assign w_edge = w_s & ~r_prev;
  assign w_ack  = (r_state == c_PRESENT) && irq_ack;

  always_comb begin
    w_clr = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      w_clr[i] = w_ack && (r_irq_id == i[CODE_W-2:0]);
    end
  end

  // A fresh edge wins over a same-cycle ack clear; the acked request is then
  // not counted as an overrun because the old instance was just consumed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_prev <= '0;
      r_pend <= '0;
      r_ovr  <= '0;
    end else begin
      r_prev <= w_s;
      r_pend <= (r_pend & ~w_clr) | w_edge;
      r_ovr  <= (clr_overrun ? '0 : r_ovr) | (w_edge & r_pend & ~w_clr);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= c_IDLE;
      r_irq_id <= '0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (enc_code[CODE_W-1]) begin
            r_irq_id <= enc_code[CODE_W-2:0];
            r_state  <= c_PRESENT;
          end
        end
        c_PRESENT: begin
          if (irq_ack) begin
            r_state <= c_IDLE;
          end
        end
        default: r_state <= c_IDLE;
      endcase
    end
  end

  assign pend_out  = r_pend & ~mask;
  assign irq_valid = (r_state == c_PRESENT);
  assign irq_id    = r_irq_id;
  assign overrun   = r_ovr;

endmodule
`default_nettype wire

// File: tb/tb_irq_request_latch.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_request_latch
// Brief    : Self-checking bench for irq_request_latch with a highest-index-wins
//            encoder model and an expected-channel scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_request_latch;

`ifdef IRQ_LATCH_SYNC_EN
  localparam int c_LAT = 2;
`else
  localparam int c_LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] irq_in = '0;
  logic [3:0] mask = '0;
  logic [3:0] pend_out;
  logic [2:0] enc_code;
  logic       irq_valid;
  logic [1:0] irq_id;
  logic       irq_ack = 1'b0;
  logic [3:0] overrun;
  logic       clr_overrun = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    string      name;
    logic [3:0] pulse;
    logic [3:0] msk;
    logic [3:0] exp_pend;
    logic       exp_valid;
    logic [1:0] exp_id;
  } vec_t;

  vec_t vecs[4];

  irq_request_latch dut (
    .clk        (clk),
    .rst        (rst),
    .irq_in     (irq_in),
    .mask       (mask),
    .pend_out   (pend_out),
    .enc_code   (enc_code),
    .irq_valid  (irq_valid),
    .irq_id     (irq_id),
    .irq_ack    (irq_ack),
    .overrun    (overrun),
    .clr_overrun(clr_overrun)
  );

  always #5 clk = ~clk;

  // Encoder model: highest pending index wins
  always_comb begin
    enc_code = 3'b000;
    for (int i = 0; i < 4; i++) begin
      if (pend_out[i]) enc_code = {1'b1, 2'(i)};
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_present(input string name);
    check({name, "_valid"}, 32'(irq_valid), 32'd1);
    if (exp_q.size() == 0) begin
      check({name, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      check({name, "_id"}, 32'(irq_id), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic do_reset();
    irq_in = '0; mask = '0; irq_ack = 1'b0; clr_overrun = 1'b0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // One-cycle pulse; returns once the pending bit should be visible
  task automatic pulse(input logic [3:0] p);
    irq_in = p;
    tick();
    irq_in = '0;
    repeat (c_LAT) tick();
  endtask

  task automatic do_ack(input string name);
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    check({name, "_ack_valid"}, 32'(irq_valid), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{"ch2",        4'b0100, 4'b0000, 4'b0100, 1'b1, 2'd2};
    vecs[1] = '{"ch3_masked", 4'b1000, 4'b1000, 4'b0000, 1'b0, 2'd0};
    vecs[2] = '{"ch1_m0",     4'b0010, 4'b0001, 4'b0010, 1'b1, 2'd1};
    vecs[3] = '{"ch30_m3",    4'b1001, 4'b1000, 4'b0001, 1'b1, 2'd0};

    // Reset state
    tick();
    check("rst_pend", 32'(pend_out), 32'd0);
    check("rst_valid", 32'(irq_valid), 32'd0);
    check("rst_id", 32'(irq_id), 32'd0);
    check("rst_ovr", 32'(overrun), 32'd0);
    do_reset();

    // Table-driven single-pulse vectors
    foreach (vecs[v]) begin
      do_reset();
      mask = vecs[v].msk;
      if (vecs[v].exp_valid) exp_q.push_back(vecs[v].exp_id);
      pulse(vecs[v].pulse);
      check({vecs[v].name, "_pend"}, 32'(pend_out), 32'(vecs[v].exp_pend));
      check({vecs[v].name, "_early"}, 32'(irq_valid), 32'd0);
      tick();
      if (vecs[v].exp_valid) begin
        expect_present(vecs[v].name);
        do_ack(vecs[v].name);
        check({vecs[v].name, "_ack_pend"}, 32'(pend_out), 32'd0);
      end else begin
        check({vecs[v].name, "_valid"}, 32'(irq_valid), 32'd0);
      end
    end

    // Two simultaneous edges: ch1 first, one idle cycle, then ch0
    do_reset();
    exp_q.push_back(2'd1);
    exp_q.push_back(2'd0);
    pulse(4'b0011);
    tick();
    expect_present("dual_first");
    do_ack("dual_first");
    check("dual_pend", 32'(pend_out), 32'b0001);
    tick();
    expect_present("dual_second");
    do_ack("dual_second");

    // Masked ch3 appears once unmasked
    do_reset();
    mask = 4'b1000;
    pulse(4'b1000);
    tick(); tick();
    check("mask_pend", 32'(pend_out), 32'd0);
    check("mask_valid", 32'(irq_valid), 32'd0);
    mask = 4'b0000;
    #1;
    check("unmask_pend", 32'(pend_out), 32'b1000);
    exp_q.push_back(2'd3);
    tick();
    expect_present("unmask");
    do_ack("unmask");

    // Overrun on a second ch0 edge, then clear
    do_reset();
    exp_q.push_back(2'd0);
    pulse(4'b0001);
    tick();
    pulse(4'b0001);
    check("ovr_set", 32'(overrun), 32'b0001);
    clr_overrun = 1'b1;
    tick();
    clr_overrun = 1'b0;
    check("ovr_clr", 32'(overrun), 32'd0);
    expect_present("ovr_present");
    do_ack("ovr");

    // New ch1 edge coinciding with ack of ch1
    do_reset();
    exp_q.push_back(2'd1);
    pulse(4'b0010);
    tick();
    expect_present("reack_first");
    irq_in = 4'b0010;
    repeat (c_LAT) tick();
    irq_ack = 1'b1;
    tick();
    irq_ack = 1'b0;
    irq_in = '0;
    check("reack_pend", 32'(pend_out), 32'b0010);
    check("reack_ovr", 32'(overrun), 32'd0);
    check("reack_gap", 32'(irq_valid), 32'd0);
    exp_q.push_back(2'd1);
    tick();
    expect_present("reack_second");
    do_ack("reack_second");

    // Async reset mid-handshake, with a line held high through reset
    do_reset();
    pulse(4'b0100);
    tick();
    pulse(4'b0100);
    check("rmid_ovr_pre", 32'(overrun), 32'b0100);
    check("rmid_valid_pre", 32'(irq_valid), 32'd1);
    irq_in = 4'b1000;
    #2;
    rst = 1'b1;
    #1;
    check("rmid_valid", 32'(irq_valid), 32'd0);
    check("rmid_pend", 32'(pend_out), 32'd0);
    check("rmid_ovr", 32'(overrun), 32'd0);
    tick(); tick();
    rst = 1'b0;
    exp_q.delete();
    repeat (c_LAT + 1) tick();
    check("held_pend", 32'(pend_out), 32'b1000);
    exp_q.push_back(2'd3);
    tick();
    expect_present("held");
    irq_in = '0;
    do_ack("held");
    repeat (c_LAT + 2) tick();
    check("held_once", 32'(pend_out), 32'd0);
    check("held_idle", 32'(irq_valid), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/irq_request_latch.md
# irq_request_latch

- Upstream stage of the 4-input priority encoder.
- Synchronises four asynchronous interrupt request lines and detects their rising edges.
- Holds one pending bit per channel and drives the masked pending vector into the encoder input.
- Consumes the encoder's code and presents the winning channel to the core over a valid/ack handshake; an acked channel's pending bit is cleared.

## Interface
- CHANNELS, 4, number of request lines; fixed at 4 to match the encoder input width.
- CODE_W, 3, encoder code width: bit 2 = any-valid, bits 1:0 = winning channel index.
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- irq_in  input  4  raw request lines, asynchronous to clk.
- mask  input  4  1 = channel masked (still latched, not forwarded).
- pend_out  output  4  pending & ~mask, combinational from registers; drives encoder inp.
- enc_code  input  3  encoder Y: {valid, index[1:0]}.
- irq_valid  output  1  a channel is being presented to the core.
- irq_id  output  2  presented channel index; stable while irq_valid=1.
- irq_ack  input  1  core accepts the presented channel.
- overrun  output  4  sticky: a new edge arrived while that channel was already pending.
- clr_overrun  input  1  clears all overrun bits.

## Operation
- Input path: irq_in -> optional synchroniser -> s (4 bits) -> prev register; edge = s & ~prev.
- pending[i] set on edge[i]; cleared on accepted ack for i; set has priority over clear in the same cycle.
- overrun[i] set when edge[i]=1 and pending[i]=1 and no clear of i that cycle; cleared only by clr_overrun (a set in the same cycle wins).
- Masking affects only pend_out; masked edges are still recorded and appear when unmasked.
- FSM, 2 states:
  - IDLE: irq_valid=0; if enc_code[2]=1, capture irq_id<=enc_code[1:0] and go to PRESENT.
  - PRESENT: irq_valid=1; on irq_ack=1, clear pending[irq_id] and go to IDLE; otherwise stay.
- The presented channel stays presented until acked, even if it becomes masked or a higher channel becomes pending (no preemption).
- irq_ack in IDLE is ignored.
- enc_code is trusted; index is ignored when enc_code[2]=0.

## Timing
- Reset (async assert, clean sync release): pending=0, prev=0, sync flops=0, overrun=0, state=IDLE, irq_valid=0, irq_id=0; pend_out therefore 0.
- Because prev resets to 0, a line held high through reset registers one event after release.
- Edge k = first clk edge sampling irq_in high. With sync: pending set at edge k+2, irq_valid high after edge k+3. Without sync: pending at k, irq_valid after k+1.
- Ack accepted at edge a: irq_valid low after a. The next pending channel is captured at edge a+1 and presented after a+1; minimum one idle cycle between presentations.
- Reset asserted mid-handshake: immediate return to the reset values; outstanding requests are lost.

## Configuration
- IRQ_LATCH_SYNC_EN defined: 2-flop synchroniser per channel ahead of edge detect (+2 cycles latency).
- IRQ_LATCH_SYNC_EN undefined: irq_in feeds the edge detector directly; irq_in must be synchronous to clk.

## Test plan
- Reset then irq_in=4'b0100 pulse, mask=0 -> pend_out=4'b0100, irq_valid=1 with irq_id=2 at the stated latency; ack -> pend_out=0, irq_valid=0.
- irq_in 4'b0011 same cycle, encoder model (highest index wins) -> irq_id=1 presented, ack, then irq_id=0 after one idle cycle.
- mask=4'b1000, pulse ch3 -> pend_out=0, irq_valid=0; clear mask -> ch3 presented with irq_id=3.
- Two ch0 pulses without ack -> overrun=4'b0001; clr_overrun -> overrun=0; pending ch0 still presented.
- ch1 edge in the same cycle as ack of ch1 -> pending[1] stays 1, overrun[1]=0, ch1 re-presented.
- rst asserted while irq_valid=1 -> irq_valid=0, pend_out=0, overrun=0 immediately; irq_in held high through reset -> one event after release.
